vsensor_ctrl: RTL
=================

# vsensor_ctrl

Readout controller for the voltage sensor macro. It drives the sensor's gated enable, calibration request and offset trim. It waits for calibration to complete, then collects a fixed burst of sensor samples and produces a truncated average. Sits between the PVT register bank and the sensor wrapper, consuming the sensor's o_valid / calib_done / o_data outputs.

## Interface
- AVG_LOG2, 3: log2 of samples averaged per measurement (N = 2^AVG_LOG2, 0..6)
- TIMEOUT, 1024: max cycles waited for calib_done or for each sample before error (>=2)

- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request for a calibrate+measure sequence
- offset_cfg  in  10  offset trim captured on accepted start
- sen_en  out  1  sensor clock enable
- sen_calib  out  1  sensor calibration request
- sen_offset  out  10  registered offset to sensor
- sen_valid  in  1  sensor sample strobe
- sen_calib_done  in  1  sensor calibration complete
- sen_data  in  10  sensor sample
- busy  out  1  high in CALIB or SAMPLE
- done  out  1  one-cycle pulse, measurement complete
- avg_data  out  10  last average, held until next done
- timeout_err  out  1  sticky error flag
- min_data  out  10  minimum sample of last burst (macro-dependent)
- max_data  out  10  maximum sample of last burst (macro-dependent)

## Operation
- FSM states: IDLE, CALIB, SAMPLE, DONE, ERR.
- IDLE
  - sen_en=0, sen_calib=0.
  - start=1: latch offset_cfg into sen_offset, clear timeout_err, clear accumulator/count/timer, go CALIB.
- CALIB
  - sen_en=1, sen_calib=1.
  - sen_calib_done=1: go SAMPLE and clear the timer.
  - sen_valid is ignored in this state.
- SAMPLE
  - sen_en=1, sen_calib=0.
  - Each cycle with sen_valid=1 adds sen_data to the accumulator and increments count. The accumulator is 10+AVG_LOG2 bits wide and zero-extended, so it cannot overflow.
  - Each accepted sample clears the timer.
  - On the N-th accepted sample, register avg_data = (acc + sen_data) >> AVG_LOG2 (truncating), then go DONE.
- DONE: one cycle; done=1, sen_en=0; go IDLE.
- ERR
  - One cycle; set timeout_err=1, sen_en=0, sen_calib=0; go IDLE.
  - done is not pulsed, and avg_data keeps its previous value.
- Timer
  - Counts every cycle in CALIB/SAMPLE.
  - If timer == TIMEOUT-1 and no qualifying event occurs that cycle, go ERR.
  - If the qualifying event (calib_done in CALIB, valid in SAMPLE) arrives in the same cycle, the event wins.
- start outside IDLE is ignored, including during DONE/ERR.
- sen_calib_done in SAMPLE/IDLE is ignored.

## Timing
- Reset values:
  - state=IDLE; all outputs 0.
  - sen_offset=0, avg_data=0, min_data=0, max_data=0, timeout_err=0.
- start at edge k:
  - sen_en, sen_calib and busy high from cycle k+1.
- calib_done sampled at edge m: sen_calib low from cycle m+1.
- Last sample accepted at edge j:
  - done=1 and new avg_data visible in cycle j+1.
  - busy=0 in cycle j+1; IDLE at j+2.
- Back-to-back: a start is accepted at the earliest 2 cycles after the last sample.
- Minimum sequence: 1 cycle CALIB + N cycles SAMPLE + 1 cycle DONE.
- Asserting rstn low mid-sequence immediately returns IDLE and clears all outputs, including timeout_err and avg_data.

## Configuration
- VSENSOR_MINMAX_EN defined:
  - Track per-burst min/max of accepted samples; trackers are seeded with the first sample of the burst.
  - min_data/max_data are registered together with avg_data at the N-th sample.
- Undefined: no tracking logic; min_data and max_data tied to 0.

## Test plan
- Nominal, AVG_LOG2=3: start with offset_cfg=10'h155; calib_done after 5 cycles; samples 100..107 on consecutive cycles.
  - Expect avg_data=103, done one cycle after sample 107, sen_offset=10'h155.
  - With the macro, expect min_data=100, max_data=107.
- Calibration timeout, TIMEOUT=16: start, no calib_done.
  - ERR entered after 16 CALIB cycles; timeout_err=1, no done pulse, avg_data unchanged.
  - A subsequent start clears timeout_err.
- Sample gap timeout: 4 samples, then silence.
  - timeout_err=1 after TIMEOUT idle SAMPLE cycles; no done.
  - Boundary: a sample arriving exactly at timer=TIMEOUT-1 is accepted and no error is raised.
- Ignored inputs:
  - sen_valid pulses during CALIB are not accumulated.
  - start pulses during SAMPLE and DONE change nothing.
  - Full-scale burst of 8×1023 gives avg_data=1023.
- Reset mid-SAMPLE (after 3 samples): all outputs 0 on the cycle rstn falls; a new start runs a clean 8-sample burst with the correct average.

Source files
------------

// File: rtl/vsensor_ctrl.sv
// Voltage sensor readout controller: calibrate, collect 2^AVG_LOG2 samples, report truncated average.
// Optional per-burst min/max tracking enabled by defining VSENSOR_MINMAX_EN.
module vsensor_ctrl #(
   parameter int unsigned AVG_LOG2 = 3,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [9:0] offset_cfg,
   output logic       sen_en,
   output logic       sen_calib,
   output logic [9:0] sen_offset,
   input  logic       sen_valid,
   input  logic       sen_calib_done,
   input  logic [9:0] sen_data,
   output logic       busy,
   output logic       done,
   output logic [9:0] avg_data,
   output logic       timeout_err,
   output logic [9:0] min_data,
   output logic [9:0] max_data
);

   localparam int unsigned DW    = 10;
   localparam int unsigned ACC_W = DW + AVG_LOG2;
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CALIB  = 3'd1;
   localparam logic [2:0] ST_SAMPLE = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [DW-1:0]    offset_q, offset_d;
   logic [DW-1:0]    avg_q, avg_d;
   logic             err_q, err_d;
   logic             sen_en_q, sen_en_d;
   logic             sen_calib_q, sen_calib_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [ACC_W-1:0] sum_c;

   assign sum_c = acc_q + ACC_W'(sen_data);

`ifdef VSENSOR_MINMAX_EN
   logic [DW-1:0] mn_q, mn_d, mx_q, mx_d;
   logic [DW-1:0] min_out_q, min_out_d, max_out_q, max_out_d;
   logic [DW-1:0] mn_next_c, mx_next_c;

   // First sample of a burst seeds both trackers
   assign mn_next_c = (cnt_q == '0 || sen_data < mn_q) ? sen_data : mn_q;
   assign mx_next_c = (cnt_q == '0 || sen_data > mx_q) ? sen_data : mx_q;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      offset_d    = offset_q;
      avg_d       = avg_q;
      err_d       = err_q;
      sen_en_d    = 1'b0;
      sen_calib_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
`ifdef VSENSOR_MINMAX_EN
      mn_d        = mn_q;
      mx_d        = mx_q;
      min_out_d   = min_out_q;
      max_out_d   = max_out_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               offset_d = offset_cfg;
               err_d    = 1'b0;
               acc_d    = '0;
               cnt_d    = '0;
               tmr_d    = '0;
               state_d  = ST_CALIB;
            end
         end
         ST_CALIB: begin
            if (sen_calib_done) begin
               tmr_d   = '0;
               state_d = ST_SAMPLE;
            end else if (tmr_q == TMR_MAX) begin
               state_d = ST_ERR;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_SAMPLE: begin
            // An arriving sample beats the timeout in the same cycle
            if (sen_valid) begin
               acc_d = sum_c;
               cnt_d = cnt_q + CNT_W'(1);
               tmr_d = '0;
`ifdef VSENSOR_MINMAX_EN
               mn_d  = mn_next_c;
               mx_d  = mx_next_c;
`endif
               if (cnt_q == LAST_CNT) begin
                  avg_d   = DW'(sum_c >> AVG_LOG2);
`ifdef VSENSOR_MINMAX_EN
                  min_out_d = mn_next_c;
                  max_out_d = mx_next_c;
`endif
                  state_d = ST_DONE;
               end
            end else if (tmr_q == TMR_MAX) begin
               state_d = ST_ERR;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs decoded from the next state
      sen_en_d    = (state_d == ST_CALIB) || (state_d == ST_SAMPLE);
      sen_calib_d = (state_d == ST_CALIB);
      busy_d      = sen_en_d;
      done_d      = (state_d == ST_DONE);
      if (state_d == ST_ERR) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         offset_q    <= '0;
         avg_q       <= '0;
         err_q       <= 1'b0;
         sen_en_q    <= 1'b0;
         sen_calib_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         offset_q    <= offset_d;
         avg_q       <= avg_d;
         err_q       <= err_d;
         sen_en_q    <= sen_en_d;
         sen_calib_q <= sen_calib_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef VSENSOR_MINMAX_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mn_q      <= '0;
         mx_q      <= '0;
         min_out_q <= '0;
         max_out_q <= '0;
      end else begin
         mn_q      <= mn_d;
         mx_q      <= mx_d;
         min_out_q <= min_out_d;
         max_out_q <= max_out_d;
      end
   end

   assign min_data = min_out_q;
   assign max_data = max_out_q;
`else
   assign min_data = '0;
   assign max_data = '0;
`endif

   assign sen_en      = sen_en_q;
   assign sen_calib   = sen_calib_q;
   assign sen_offset  = offset_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign avg_data    = avg_q;
   assign timeout_err = err_q;

endmodule
